rx_serial_7e2: RTL

Serial receiver for the asynchronous 7E2 frame (1 start, 7 data LSB-first, even parity, 2 stop) that our serial transmitter produces. It sits between the board's RX pin and the character-consuming logic. It detects a start bit, samples each bit at mid-period, assembles the ASCII character, and checks parity and stop bits. The character is then held with a presence flag until the consumer acknowledges it.

---
 rtl/rx_serial_7e2_pkg.sv | 26 ++
 rtl/rx_serial_7e2_if.sv | 26 ++
 rtl/rx_serial_7e2_uc.sv | 74 +++++++
 rtl/rx_serial_7e2.sv | 104 ++++++++++
 4 files changed

// File: rtl/rx_serial_7e2_pkg.sv
// Shared types and frame constants for the 7E2 serial receiver.
// Used by rx_serial_7e2 and its control unit rx_serial_7e2_uc.
package rx_serial_7e2_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'b0000,
        PREPARACAO    = 4'b0001,
        ESPERA        = 4'b0011,
        RECEPCAO      = 4'b0111,
        ARMAZENAMENTO = 4'b1000,
        FINAL_RX      = 4'b1111,
        DADO_PRESENTE = 4'b1100
    } estado_t;

    localparam logic [3:0] DBG_ILEGAL = 4'b1110;

    localparam int N_DADOS    = 7;
    localparam int N_AMOSTRAS = 11;
    localparam bit PARIDADE_PAR = 1'b1;

    // True when data + parity bit satisfy the configured parity
    function automatic logic paridade_ok_f(input logic [N_DADOS:0] v);
        return PARIDADE_PAR ? ~(^v) : (^v);
    endfunction

endpackage

// File: rtl/rx_serial_7e2_if.sv
// Line/consumer bundle of the 7E2 serial receiver.
// master = line driver + consumer side, slave = receiver.
interface rx_serial_7e2_if;

    logic       dado_serial;
    logic       recebe_dado;
    logic [6:0] dados_ascii;
    logic       paridade_ok;
    logic       erro_parada;
    logic       pronto_rx;
    logic       tem_dado;
    logic [3:0] db_estado;

    modport master (
        output dado_serial, recebe_dado,
        input  dados_ascii, paridade_ok, erro_parada,
        input  pronto_rx, tem_dado, db_estado
    );

    modport slave (
        input  dado_serial, recebe_dado,
        output dados_ascii, paridade_ok, erro_parada,
        output pronto_rx, tem_dado, db_estado
    );

endinterface

// File: rtl/rx_serial_7e2_uc.sv
// Control unit of the 7E2 receiver: frame FSM, Moore outputs,
// debug state code.
module rx_serial_7e2_uc
    import rx_serial_7e2_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       linha_i,
    input  logic       tick_i,
    input  logic       inicio_i,
    input  logic       fim_i,
    input  logic       recebe_i,
    output logic       limpa_o,
    output logic       desloca_o,
    output logic       carrega_o,
    output logic       pronto_o,
    output logic       tem_dado_o,
    output logic [3:0] db_estado_o
);

    estado_t state_q, state_d;
    logic    pronto_q, tem_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INICIAL:       state_d = linha_i ? INICIAL : PREPARACAO;
            PREPARACAO:    state_d = ESPERA;
            ESPERA: begin
                if (fim_i)       state_d = ARMAZENAMENTO;
                else if (tick_i) state_d = RECEPCAO;
            end
            // A high start-bit sample means the falling edge was a glitch
            RECEPCAO:      state_d = (inicio_i && linha_i) ? INICIAL : ESPERA;
            ARMAZENAMENTO: state_d = FINAL_RX;
            FINAL_RX:      state_d = DADO_PRESENTE;
            DADO_PRESENTE: begin
                if (!linha_i)      state_d = PREPARACAO;
                else if (recebe_i) state_d = INICIAL;
            end
            default:       state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= INICIAL;
            pronto_q <= 1'b0;
            tem_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pronto_q <= (state_d == FINAL_RX);
            tem_q    <= (state_d == DADO_PRESENTE);
        end
    end

    always_comb begin
        db_estado_o = DBG_ILEGAL;
        case (state_q)
            INICIAL, PREPARACAO, ESPERA, RECEPCAO,
            ARMAZENAMENTO, FINAL_RX, DADO_PRESENTE:
                db_estado_o = state_q;
            default:
                db_estado_o = DBG_ILEGAL;
        endcase
    end

    assign limpa_o    = (state_q == PREPARACAO);
    assign desloca_o  = (state_q == RECEPCAO) && !(inicio_i && linha_i);
    assign carrega_o  = (state_q == ARMAZENAMENTO);
    assign pronto_o   = pronto_q;
    assign tem_dado_o = tem_q;

endmodule

// File: rtl/rx_serial_7e2.sv
// 7E2 asynchronous serial receiver: datapath plus control unit.
// Define RX_SERIAL_SYNC_EN to add a 2-flop input synchronizer.
module rx_serial_7e2
    import rx_serial_7e2_pkg::*;
#(
    parameter int DIVISOR = 5208
)(
    input  logic           clock,
    input  logic           reset,
    rx_serial_7e2_if.slave bus
);

    localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 2;
    localparam logic [CW-1:0] TICK_MAX = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] TICK_MID = CW'(DIVISOR / 2 - 1);

    logic                  linha;
    logic [CW-1:0]         tick_q, tick_d;
    logic [3:0]            bit_q, bit_d;
    logic [N_AMOSTRAS-1:0] sr_q, sr_d;
    logic [N_DADOS-1:0]    dados_q;
    logic                  par_q, err_q;
    logic                  limpa, desloca, carrega;
    logic                  tick, inicio, fim;
    logic                  pronto, tem_dado;
    logic [3:0]            db_estado;

`ifdef RX_SERIAL_SYNC_EN
    logic [1:0] sync_q;

    // Reset to idle so the synchronizer never fakes a start bit
    always_ff @(posedge clock) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], bus.dado_serial};
    end

    assign linha = sync_q[1];
`else
    assign linha = bus.dado_serial;
`endif

    assign tick   = (tick_q == TICK_MID);
    assign inicio = (bit_q == 4'd0);
    assign fim    = (bit_q == 4'(N_AMOSTRAS));

    always_comb begin
        tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
        bit_d  = bit_q;
        sr_d   = sr_q;
        if (limpa) begin
            tick_d = '0;
            bit_d  = '0;
            sr_d   = '0;
        end else if (desloca) begin
            bit_d = bit_q + 4'd1;
            sr_d  = {linha, sr_q[N_AMOSTRAS-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q  <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            dados_q <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tick_q <= tick_d;
            bit_q  <= bit_d;
            sr_q   <= sr_d;
            // sr_q: [0] start, [7:1] data, [8] parity, [10:9] stops
            if (carrega) begin
                dados_q <= sr_q[N_DADOS:1];
                par_q   <= paridade_ok_f(sr_q[N_DADOS+1:1]);
                err_q   <= sr_q[0] | ~(sr_q[9] & sr_q[10]);
            end
        end
    end

    rx_serial_7e2_uc u_uc (
        .clock       (clock),
        .reset       (reset),
        .linha_i     (linha),
        .tick_i      (tick),
        .inicio_i    (inicio),
        .fim_i       (fim),
        .recebe_i    (bus.recebe_dado),
        .limpa_o     (limpa),
        .desloca_o   (desloca),
        .carrega_o   (carrega),
        .pronto_o    (pronto),
        .tem_dado_o  (tem_dado),
        .db_estado_o (db_estado)
    );

    assign bus.dados_ascii = dados_q;
    assign bus.paridade_ok = par_q;
    assign bus.erro_parada = err_q;
    assign bus.pronto_rx   = pronto;
    assign bus.tem_dado    = tem_dado;
    assign bus.db_estado   = db_estado;

endmodule
